// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the M-extension multiply/divide unit:
//   - funct3 codes selecting MUL..REMU
//   - FSM state encoding of alu_muldiv
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // funct3[2] set means a divide/remainder operation
    function automatic logic is_div_op(input logic [2:0] sel);
        return sel[2];
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
// Iterative RV32M/RV64M multiply/divide unit, one bit per cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new operation (out_ready = 1)
// CALC  | XLEN shift-add (multiply) or restoring-subtract (divide) steps
// FIXUP | sign correction and high/low word selection
// DONE  | result held on out_data with out_valid = 1 until in_ready
//
// Ports:
//   in_clk, in_rst_n        clock, async active-low reset
//   in_valid / out_ready    operation request handshake
//   in_select               funct3 (MUL..REMU)
//   in_data1, in_data2      rs1, rs2
//   in_kill                 abort in-flight op / block acceptance
//   out_valid / in_ready    result handshake
//   out_data                result
// -----------------------------------------------------------------------------
module alu_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    input  logic            in_valid,
    output logic            out_ready,
    input  logic [2:0]      in_select,
    input  logic [XLEN-1:0] in_data1,
    input  logic [XLEN-1:0] in_data2,
    input  logic            in_kill,
    output logic            out_valid,
    input  logic            in_ready,
    output logic [XLEN-1:0] out_data
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_op;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_sel;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_valid;
    logic [XLEN-1:0]   r_data;

    // ---------------------------------------------------------------- capture
    logic            w_s1_signed;
    logic            w_s2_signed;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_accept;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_data;

    always_comb begin
        w_s1_signed = 1'b0;
        w_s2_signed = 1'b0;
        case (in_select)
            F3_MUL:    begin w_s1_signed = 1'b0; w_s2_signed = 1'b0; end
            F3_MULH:   begin w_s1_signed = 1'b1; w_s2_signed = 1'b1; end
            F3_MULHSU: begin w_s1_signed = 1'b1; w_s2_signed = 1'b0; end
            F3_MULHU:  begin w_s1_signed = 1'b0; w_s2_signed = 1'b0; end
            F3_DIV:    begin w_s1_signed = 1'b1; w_s2_signed = 1'b1; end
            F3_DIVU:   begin w_s1_signed = 1'b0; w_s2_signed = 1'b0; end
            F3_REM:    begin w_s1_signed = 1'b1; w_s2_signed = 1'b1; end
            F3_REMU:   begin w_s1_signed = 1'b0; w_s2_signed = 1'b0; end
            default:   begin w_s1_signed = 1'b0; w_s2_signed = 1'b0; end
        endcase
    end

    assign w_neg1   = w_s1_signed & in_data1[XLEN-1];
    assign w_neg2   = w_s2_signed & in_data2[XLEN-1];
    // MOST_NEG maps to itself, which is the correct unsigned magnitude
    assign w_mag1   = w_neg1 ? (~in_data1 + 1'b1) : in_data1;
    assign w_mag2   = w_neg2 ? (~in_data2 + 1'b1) : in_data2;
    assign w_accept = in_valid & out_ready & ~in_kill;

    assign w_div0    = is_div_op(in_select) & (in_data2 == '0);
    assign w_ovf     = ((in_select == F3_DIV) || (in_select == F3_REM))
                       & (in_data1 == MOST_NEG) & (in_data2 == '1);
    assign w_special = w_div0 | w_ovf;

    always_comb begin
        w_special_data = '0;
        if (in_select[1]) begin
            // REM/REMU: divide by zero returns the dividend, overflow returns 0
            w_special_data = w_div0 ? in_data1 : '0;
        end else begin
            w_special_data = w_div0 ? '1 : MOST_NEG;
        end
    end

    // ---------------------------------------------------------------- iterate
    // Multiply: add multiplicand into the high half when the low bit is set,
    // then shift the whole accumulator right, carry included.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: shift left, trial-subtract the divisor from the partial
    // remainder, and shift in a 1 as quotient bit when it fits.
    logic [XLEN:0]     w_div_hi;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_next;
    assign w_div_hi   = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff = w_div_hi - {1'b0, r_op};
    assign w_div_next = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // ---------------------------------------------------------------- fixup
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_result = '0;
        case (r_sel)
            F3_MUL:                       w_result = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              w_result = w_quo;
            F3_REM, F3_REMU:              w_result = w_rem;
            default:                      w_result = '0;
        endcase
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sel   <= in_select;
                        r_neg_q <= w_neg1 ^ w_neg2;
                        r_neg_r <= w_neg1;
                        if (w_special) begin
                            r_data  <= w_special_data;
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            // multiply keeps the multiplier in the accumulator
                            // and the multiplicand in r_op; divide keeps the
                            // dividend in the accumulator and the divisor in r_op
                            r_acc   <= {{XLEN{1'b0}}, is_div_op(in_select) ? w_mag1 : w_mag2};
                            r_op    <= is_div_op(in_select) ? w_mag2 : w_mag1;
                            r_cnt   <= CW'(XLEN);
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (in_kill) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= is_div_op(r_sel) ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= ST_FIXUP;
                        end
                    end
                end
                ST_FIXUP: begin
                    if (in_kill) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_data  <= w_result;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (in_kill || in_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_ready = (r_state == ST_IDLE);
    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
    localparam int XLEN = 32;
    localparam int LAT_NORMAL  = XLEN + 2;
    localparam int LAT_SPECIAL = 1;

    logic            in_clk;
    logic            in_rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [2:0]      in_select;
    logic [XLEN-1:0] in_data1;
    logic [XLEN-1:0] in_data2;
    logic            in_kill;
    logic            out_valid;
    logic            in_ready;
    logic [XLEN-1:0] out_data;

    int n_checks = 0;
    int n_fails  = 0;

    alu_muldiv #(.XLEN(XLEN)) dut (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_select (in_select),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_kill   (in_kill),
        .out_valid (out_valid),
        .in_ready  (in_ready),
        .out_data  (out_data)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    // drive a request for one edge; the unit must leave IDLE on acceptance
    task automatic issue(input logic [2:0] sel, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        in_select = sel;
        in_data1  = a;
        in_data2  = b;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        check("accept_ready_low", {31'd0, out_ready}, 32'd0);
    endtask

    // lat = 1 means visible right after the accept edge
    task automatic wait_result(input string tag, input int exp_lat, input logic [XLEN-1:0] exp);
        int lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_data"}, out_data, exp);
    endtask

    task automatic do_op(input string tag, input logic [2:0] sel, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input int exp_lat, input logic [XLEN-1:0] exp);
        in_ready = 1'b1;
        issue(sel, a, b);
        wait_result(tag, exp_lat, exp);
        step();
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, out_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        in_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_select = 3'b000;
        in_data1  = '0;
        in_data2  = '0;
        in_kill   = 1'b0;
        in_ready  = 1'b1;
        #23;
        check("rst_ready", {31'd0, out_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        in_rst_n = 1'b1;
        step();

        // multiply
        do_op("mul_7_m3",  3'b000, 32'd7,         32'hFFFF_FFFD, LAT_NORMAL, 32'hFFFF_FFEB);
        do_op("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, LAT_NORMAL, 32'h4000_0000);
        do_op("mulhu_ff",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_NORMAL, 32'hFFFF_FFFE);
        do_op("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_NORMAL, 32'hFFFF_FFFF);
        do_op("mulh_m3_7", 3'b001, 32'hFFFF_FFFD, 32'd7,         LAT_NORMAL, 32'hFFFF_FFFF);

        // divide
        do_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, LAT_NORMAL, 32'hFFFF_FFFD);
        do_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, LAT_NORMAL, 32'hFFFF_FFFF);
        do_op("divu_100_7", 3'b101, 32'd100,      32'd7, LAT_NORMAL, 32'd14);
        do_op("remu_100_7", 3'b111, 32'd100,      32'd7, LAT_NORMAL, 32'd2);
        do_op("div_7_m2",  3'b100, 32'd7, 32'hFFFF_FFFE, LAT_NORMAL, 32'hFFFF_FFFD);
        do_op("rem_7_m2",  3'b110, 32'd7, 32'hFFFF_FFFE, LAT_NORMAL, 32'd1);

        // special cases
        do_op("divu_by0",  3'b101, 32'd5, 32'd0, LAT_SPECIAL, 32'hFFFF_FFFF);
        do_op("remu_by0",  3'b111, 32'd5, 32'd0, LAT_SPECIAL, 32'd5);
        do_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, LAT_SPECIAL, 32'h8000_0000);
        do_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, LAT_SPECIAL, 32'd0);

        // backpressure: result held, new request ignored while DONE
        in_ready = 1'b0;
        issue(3'b101, 32'd100, 32'd7);
        wait_result("bp_divu", LAT_NORMAL, 32'd14);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_select = 3'b000;
                in_data1  = 32'd3;
                in_data2  = 32'd4;
                in_valid  = 1'b1;
            end
            step();
            in_valid = 1'b0;
            check("bp_hold_data", out_data, 32'd14);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, out_ready}, 32'd0);
        end
        // request already waiting at the result handshake is taken one edge later
        in_select = 3'b011;
        in_data1  = 32'hFFFF_FFFF;
        in_data2  = 32'hFFFF_FFFF;
        in_valid  = 1'b1;
        in_ready  = 1'b1;
        step();
        check("bp_hs_valid", {31'd0, out_valid}, 32'd0);
        check("bp_hs_ready", {31'd0, out_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_next_accept", {31'd0, out_ready}, 32'd0);
        wait_result("bp_next_mulhu", LAT_NORMAL, 32'hFFFF_FFFE);
        step();
        check("bp_next_drop", {31'd0, out_valid}, 32'd0);

        // kill in IDLE blocks acceptance
        in_select = 3'b000;
        in_data1  = 32'd3;
        in_data2  = 32'd4;
        in_valid  = 1'b1;
        in_kill   = 1'b1;
        step();
        in_valid  = 1'b0;
        in_kill   = 1'b0;
        check("kill_idle_ready", {31'd0, out_ready}, 32'd1);

        // kill 10 cycles into CALC
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (10) step();
        in_kill = 1'b1;
        step();
        in_kill = 1'b0;
        check("kill_calc_ready", {31'd0, out_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen++;
            step();
        end
        check("kill_no_valid", seen, 32'd0);

        // asynchronous reset mid-CALC; out_data was 0xFFFFFFFE before
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (5) step();
        #2;
        in_rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, out_ready}, 32'd1);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_data", out_data, 32'd0);
        @(posedge in_clk);
        #3;
        in_rst_n = 1'b1;
        step();
        do_op("mul_3_4", 3'b000, 32'd3, 32'd4, LAT_NORMAL, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
